nav_route_sequencer: RTL and testbench

Route controller for the 3-bit campus-navigation FSM (locations 0–7). It accepts a destination request and drives the navigation FSM's `din`, one legal hop per cycle along a fixed shortest path. It checks each hop against the FSM's `dout` and reports completion, hop count or fault. It sits directly in front of the navigation FSM and is its only driver.

---
 rtl/nav_pkg.sv | 34 +++
 rtl/nav_route_rom.sv | 15 +
 rtl/nav_route_sequencer.sv | 115 +++++++++++
 tb/tb_nav_route_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_pkg.sv
// Shared types and the shortest-path table for the campus-navigation route
// sequencer.
//   loc_t        3-bit location code, 0..7
//   seq_state_t  sequencer FSM states
//   NEXT_HOP     [cur][dest] -> first hop of a shortest path from cur to dest.
//                Ties go to the lower-numbered hop. The diagonal holds the
//                location itself, which is the hold code.
package nav_pkg;

    typedef logic [2:0] loc_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        DONE,
        FAULT
    } seq_state_t;

    // Derived by breadth-first search over the edge list:
    //   0->1; 1->2,4; 2->3,4; 3->0,3; 4->5,7; 5->3,6; 6->7; 7->1,5
    // The longest shortest path is 3->6 (five hops: 0,1,4,5,6).
    localparam loc_t NEXT_HOP [8][8] = '{
        //   dest: 0     1     2     3     4     5     6     7
        '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1},  // cur 0
        '{3'd2, 3'd1, 3'd2, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4},  // cur 1
        '{3'd3, 3'd3, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4},  // cur 2
        '{3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0},  // cur 3
        '{3'd5, 3'd7, 3'd7, 3'd5, 3'd4, 3'd5, 3'd5, 3'd7},  // cur 4
        '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5, 3'd6, 3'd6},  // cur 5
        '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd6, 3'd7},  // cur 6
        '{3'd5, 3'd1, 3'd1, 3'd5, 3'd1, 3'd5, 3'd5, 3'd7}   // cur 7
    };

endpackage

// File: rtl/nav_route_rom.sv
// Combinational next-hop lookup.
//   cur   in  3  current location
//   dest  in  3  destination location
//   hop   out 3  first hop of the shortest path from cur to dest
module nav_route_rom
    import nav_pkg::*;
(
    input  loc_t cur,
    input  loc_t dest,
    output loc_t hop
);

    assign hop = NEXT_HOP[cur][dest];

endmodule

// File: rtl/nav_route_sequencer.sv
// Route controller in front of the campus-navigation FSM. Accepts a
// destination, drives one legal hop per cycle on nav_din, checks each hop
// against nav_dout and reports completion (done/done_hops) or a fault (err).
//   clk        in  1  clock, rising edge
//   rst        in  1  synchronous reset, active-high
//   req_valid  in  1  destination request valid
//   req_dest   in  3  requested location
//   req_ready  out 1  high only in IDLE
//   abort      in  1  cancel the route in progress
//   nav_dout   in  3  navigation FSM combinational output
//   nav_din    out 3  navigation FSM din
//   busy       out 1  state is not IDLE
//   done       out 1  one-cycle arrival pulse
//   done_hops  out 3  hops taken, valid while done
//   err        out 1  one-cycle fault pulse
//   cur_loc    out 3  registered copy of the FSM location
module nav_route_sequencer
    import nav_pkg::*;
#(
    parameter int MAX_HOPS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [2:0] req_dest,
    output logic       req_ready,
    input  logic       abort,
    input  logic [2:0] nav_dout,
    output logic [2:0] nav_din,
    output logic       busy,
    output logic       done,
    output logic [2:0] done_hops,
    output logic       err,
    output logic [2:0] cur_loc
);

    seq_state_t state, state_nxt;
    loc_t       dest_q, dest_nxt;
    loc_t       cur_nxt;
    logic [2:0] hops_q, hops_nxt;
    loc_t       hop;

    nav_route_rom u_rom (
        .cur  (cur_loc),
        .dest (dest_q),
        .hop  (hop)
    );

    // NOTE: every register is reset here; there is no memory array, so a
    // full reset costs nothing and keeps cur_loc aligned with the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cur_loc <= 3'd0;
            dest_q  <= 3'd0;
            hops_q  <= 3'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state   <= state_nxt;
            cur_loc <= cur_nxt;
            dest_q  <= dest_nxt;
            hops_q  <= hops_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable
        // unassigned, which would infer a latch.
        state_nxt = state;
        dest_nxt  = dest_q;
        cur_nxt   = cur_loc;
        hops_nxt  = hops_q;
        nav_din   = cur_loc;  // hold code: no move at any location

        case (state)
            IDLE: begin
                if (req_valid) begin
                    dest_nxt  = req_dest;
                    hops_nxt  = 3'd0;
                    state_nxt = (req_dest == cur_loc) ? DONE : ROUTE;
                end
            end
            ROUTE: begin
                // Precedence: abort > mismatch > arrival > budget.
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    nav_din = hop;
                    if (nav_dout != hop) begin
                        state_nxt = FAULT;
                    end else begin
                        cur_nxt  = hop;
                        hops_nxt = hops_q + 3'd1;
                        if (hop == dest_q) begin
                            state_nxt = DONE;
                        end else if ((int'(hops_q) + 1) == MAX_HOPS) begin
                            state_nxt = FAULT;
                        end
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            FAULT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = (state == FAULT);
    assign done_hops = hops_q;

endmodule

// File: tb/tb_nav_route_sequencer.sv
// Bench for nav_route_sequencer. A behavioural navigation FSM answers the
// main instance; a second instance with a two-hop budget talks to an ideal
// echo FSM to exercise the budget fault.
module tb_nav_route_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, abort;
    logic [2:0] req_dest;
    logic       req_ready, busy, done, err;
    logic [2:0] nav_din, nav_dout, done_hops, cur_loc;

    logic       req_valid_b;
    logic [2:0] req_dest_b;
    logic       req_ready_b, busy_b, done_b, err_b;
    logic [2:0] nav_din_b, nav_dout_b, done_hops_b, cur_loc_b;

    logic [2:0] nav_loc;
    logic       legal;
    logic       force_en;
    logic [2:0] force_val;

    int errors = 0;
    int checks = 0;

    logic [2:0] hop_q[$];
    logic [2:0] dh_q[$];

    always #5 clk = ~clk;

    nav_route_sequencer u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_dest(req_dest),
        .req_ready(req_ready), .abort(abort), .nav_dout(nav_dout),
        .nav_din(nav_din), .busy(busy), .done(done), .done_hops(done_hops),
        .err(err), .cur_loc(cur_loc)
    );

    nav_route_sequencer #(.MAX_HOPS(2)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_dest(req_dest_b),
        .req_ready(req_ready_b), .abort(1'b0), .nav_dout(nav_dout_b),
        .nav_din(nav_din_b), .busy(busy_b), .done(done_b),
        .done_hops(done_hops_b), .err(err_b), .cur_loc(cur_loc_b)
    );

    // Navigation FSM: moves only along legal edges, otherwise stays put.
    always_comb begin
        legal = 1'b0;
        case (nav_loc)
            3'd0: legal = (nav_din == 3'd1);
            3'd1: legal = (nav_din == 3'd2) || (nav_din == 3'd4);
            3'd2: legal = (nav_din == 3'd3) || (nav_din == 3'd4);
            3'd3: legal = (nav_din == 3'd0) || (nav_din == 3'd3);
            3'd4: legal = (nav_din == 3'd5) || (nav_din == 3'd7);
            3'd5: legal = (nav_din == 3'd3) || (nav_din == 3'd6);
            3'd6: legal = (nav_din == 3'd7);
            3'd7: legal = (nav_din == 3'd1) || (nav_din == 3'd5);
            default: legal = 1'b0;
        endcase
        nav_dout = force_en ? force_val : (legal ? nav_din : nav_loc);
    end

    always @(posedge clk) begin
        if (rst) nav_loc <= 3'd0;
        else     nav_loc <= nav_dout;
    end

    assign nav_dout_b = nav_din_b;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from an IDLE cycle and follows it to completion using
    // the hops queued in hop_q and the count queued in dh_q. Starts and ends at
    // the sampling point of an IDLE cycle.
    task automatic run_request(input logic [2:0] from, input logic [2:0] dest,
                               input logic hold_other);
        logic [2:0] h;
        logic [2:0] dh;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: req_ready=%0b expected 1", req_ready); end
        checks++; if (cur_loc !== from) begin errors++; $display("FAIL accept_cur_loc: cur_loc=%0d expected %0d", cur_loc, from); end
        checks++; if (nav_din !== from) begin errors++; $display("FAIL idle_hold: nav_din=%0d expected %0d", nav_din, from); end
        req_valid = 1'b1;
        req_dest  = dest;
        step();
        if (hold_other) req_dest = dest ^ 3'd5;
        else            req_valid = 1'b0;
        #1;
        while (hop_q.size() > 0) begin
            h = hop_q.pop_front();
            checks++; if (nav_din !== h) begin errors++; $display("FAIL route_hop: nav_din=%0d expected %0d (dest %0d)", nav_din, h, dest); end
            checks++; if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL route_flags: busy=%0b done=%0b err=%0b expected 1 0 0", busy, done, err); end
            step();
            #1;
        end
        req_valid = 1'b0;
        dh = dh_q.pop_front();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: done=%0b expected 1 (dest %0d)", done, dest); end
        checks++; if (done_hops !== dh) begin errors++; $display("FAIL done_hops: done_hops=%0d expected %0d", done_hops, dh); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL done_err: err=%0b expected 0", err); end
        checks++; if (nav_din !== dest) begin errors++; $display("FAIL done_hold: nav_din=%0d expected %0d", nav_din, dest); end
        step();
        #1;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL return_idle: req_ready=%0b busy=%0b done=%0b expected 1 0 0", req_ready, busy, done); end
        checks++; if (cur_loc !== dest) begin errors++; $display("FAIL final_loc: cur_loc=%0d expected %0d", cur_loc, dest); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        #1;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready_busy: req_ready=%0b busy=%0b expected 1 0", req_ready, busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0 || done_hops !== 3'd0) begin errors++; $display("FAIL reset_pulses: done=%0b err=%0b done_hops=%0d expected 0 0 0", done, err, done_hops); end
        checks++; if (cur_loc !== 3'd0 || nav_din !== 3'd0) begin errors++; $display("FAIL reset_loc: cur_loc=%0d nav_din=%0d expected 0 0", cur_loc, nav_din); end
        rst = 1'b0;
        step();
        #1;
    endtask

    task automatic test_routes();
        hop_q.push_back(3'd1); hop_q.push_back(3'd4); hop_q.push_back(3'd5); hop_q.push_back(3'd6);
        dh_q.push_back(3'd4);
        run_request(3'd0, 3'd6, 1'b0);
        hop_q.push_back(3'd7); hop_q.push_back(3'd1); hop_q.push_back(3'd2);
        dh_q.push_back(3'd3);
        run_request(3'd6, 3'd2, 1'b0);
        hop_q.push_back(3'd3);
        dh_q.push_back(3'd1);
        run_request(3'd2, 3'd3, 1'b0);
    endtask

    // req_valid stays high with another destination for the whole route.
    task automatic test_req_ignored();
        hop_q.push_back(3'd0); hop_q.push_back(3'd1); hop_q.push_back(3'd4); hop_q.push_back(3'd7);
        dh_q.push_back(3'd4);
        run_request(3'd3, 3'd7, 1'b1);
        hop_q.push_back(3'd5);
        dh_q.push_back(3'd1);
        run_request(3'd7, 3'd5, 1'b0);
    endtask

    task automatic test_zero_hop();
        dh_q.push_back(3'd0);
        run_request(3'd5, 3'd5, 1'b0);
        checks++; if (nav_din !== 3'd5) begin errors++; $display("FAIL zero_hop_hold: nav_din=%0d expected 5", nav_din); end
    endtask

    task automatic test_rst_mid_route();
        req_valid = 1'b1;
        req_dest  = 3'd0;
        step();
        req_valid = 1'b0;
        #1;
        checks++; if (nav_din !== 3'd3) begin errors++; $display("FAIL rst_route_hop: nav_din=%0d expected 3", nav_din); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || cur_loc !== 3'd0) begin errors++; $display("FAIL rst_mid_state: req_ready=%0b busy=%0b cur_loc=%0d expected 1 0 0", req_ready, busy, cur_loc); end
        checks++; if (done !== 1'b0 || err !== 1'b0 || nav_din !== 3'd0) begin errors++; $display("FAIL rst_mid_pulses: done=%0b err=%0b nav_din=%0d expected 0 0 0", done, err, nav_din); end
        step();
        #1;
        checks++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_after: done=%0b err=%0b busy=%0b expected 0 0 0", done, err, busy); end
    endtask

    task automatic test_abort();
        req_valid = 1'b1;
        req_dest  = 3'd6;
        step();
        req_valid = 1'b0;
        #1;
        checks++; if (nav_din !== 3'd1) begin errors++; $display("FAIL abort_first_hop: nav_din=%0d expected 1", nav_din); end
        step();
        abort = 1'b1;
        #1;
        checks++; if (nav_din !== 3'd1) begin errors++; $display("FAIL abort_hold: nav_din=%0d expected 1", nav_din); end
        step();
        abort = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || cur_loc !== 3'd1) begin errors++; $display("FAIL abort_idle: req_ready=%0b busy=%0b cur_loc=%0d expected 1 0 1", req_ready, busy, cur_loc); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL abort_pulses: done=%0b err=%0b expected 0 0", done, err); end
        hop_q.push_back(3'd2); hop_q.push_back(3'd3); hop_q.push_back(3'd0);
        dh_q.push_back(3'd3);
        run_request(3'd1, 3'd0, 1'b0);
    endtask

    task automatic test_mismatch();
        req_valid = 1'b1;
        req_dest  = 3'd3;
        step();
        req_valid = 1'b0;
        force_en  = 1'b1;
        force_val = 3'd0;
        #1;
        checks++; if (nav_din !== 3'd1) begin errors++; $display("FAIL mismatch_hop: nav_din=%0d expected 1", nav_din); end
        step();
        force_en = 1'b0;
        #1;
        checks++; if (err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL mismatch_err: err=%0b done=%0b expected 1 0", err, done); end
        checks++; if (cur_loc !== 3'd0 || nav_din !== 3'd0) begin errors++; $display("FAIL mismatch_loc: cur_loc=%0d nav_din=%0d expected 0 0", cur_loc, nav_din); end
        step();
        #1;
        checks++; if (err !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mismatch_idle: err=%0b done=%0b req_ready=%0b expected 0 0 1", err, done, req_ready); end
    endtask

    // Budget of two hops: 0->6 faults after hop 4; 4->6 arrives on the
    // budget hop and arrival wins.
    task automatic test_budget();
        logic [2:0] h;
        req_valid_b = 1'b1;
        req_dest_b  = 3'd6;
        hop_q.push_back(3'd1); hop_q.push_back(3'd4);
        step();
        req_valid_b = 1'b0;
        #1;
        while (hop_q.size() > 0) begin
            h = hop_q.pop_front();
            checks++; if (nav_din_b !== h) begin errors++; $display("FAIL budget_hop: nav_din=%0d expected %0d", nav_din_b, h); end
            step();
            #1;
        end
        checks++; if (err_b !== 1'b1 || done_b !== 1'b0 || cur_loc_b !== 3'd4) begin errors++; $display("FAIL budget_fault: err=%0b done=%0b cur_loc=%0d expected 1 0 4", err_b, done_b, cur_loc_b); end
        step();
        #1;
        req_valid_b = 1'b1;
        hop_q.push_back(3'd5); hop_q.push_back(3'd6);
        dh_q.push_back(3'd2);
        step();
        req_valid_b = 1'b0;
        #1;
        while (hop_q.size() > 0) begin
            h = hop_q.pop_front();
            checks++; if (nav_din_b !== h) begin errors++; $display("FAIL budget_arrive_hop: nav_din=%0d expected %0d", nav_din_b, h); end
            step();
            #1;
        end
        h = dh_q.pop_front();
        checks++; if (done_b !== 1'b1 || err_b !== 1'b0 || done_hops_b !== h) begin errors++; $display("FAIL budget_arrive: done=%0b err=%0b done_hops=%0d expected 1 0 %0d", done_b, err_b, done_hops_b, h); end
        step();
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_dest    = 3'd0;
        abort       = 1'b0;
        force_en    = 1'b0;
        force_val   = 3'd0;
        req_valid_b = 1'b0;
        req_dest_b  = 3'd0;
        test_reset();
        test_routes();
        test_req_ignored();
        test_zero_hop();
        test_rst_mid_route();
        test_abort();
        test_mismatch();
        test_budget();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
